seg7_scan_2d: RTL and testbench

Downstream display stage for the 4-bit up/down counter. It takes the counter value `cnt_in[3:0]` (0–15), which is produced in the slow 100 Hz divided-clock domain, and brings it into the `clk_ref` domain. It converts the value to two decimal digits and drives a time-multiplexed two-digit common-anode 7-segment display, with a blanking gap between digits to suppress ghosting.

---
 rtl/seg_pkg.sv | 10 +
 rtl/sync_stable.sv | 33 +++
 rtl/seg7_scan_2d.sv | 55 +++++
 tb/tb_seg7_scan_2d.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: scan-state encoding and active-low 7-segment helpers shared by display blocks
package seg_pkg;
  typedef enum logic [1:0] {S_ONES, S_GAP0, S_TENS, S_GAP1} scan_t;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [9:0][6:0] SEG_TAB = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                         7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    return d < 4'd10 ? SEG_TAB[d] : SEG_OFF;
  endfunction
endpackage

// File: rtl/sync_stable.sv
// sync_stable: 2-flop synchroniser plus stability filter; a value passes only after it holds steady
module sync_stable #(
  parameter int W          = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic         clk_ref,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYC);
  localparam logic [CW-1:0] LOAD_AT = CW'(STABLE_CYC - 1);
  logic [W-1:0] s1, s2, prev;
  logic [CW-1:0] stab_cnt;
  logic same;
  // only the settled flop s2 and its history feed logic, never the metastable-prone s1
  assign same = s2 == prev;
  always_ff @(posedge clk_ref or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      stab_cnt <= '0;
      dout <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      prev <= s2;
      stab_cnt <= !same ? '0 : stab_cnt == CMAX ? CMAX : stab_cnt + 1'b1;
      if (same && (stab_cnt == LOAD_AT || stab_cnt == CMAX)) dout <= s2;
    end
endmodule

// File: rtl/seg7_scan_2d.sv
// seg7_scan_2d: brings a 0-15 count into clk_ref and scans it onto a 2-digit common-anode display
module seg7_scan_2d
  import seg_pkg::*;
#(
  parameter int SCAN_DIV   = 62500,
  parameter int GAP_CYC    = 64,
  parameter int STABLE_CYC = 4,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic       clk_ref,
  input  logic       rst,
  input  logic [3:0] cnt_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);
  localparam int MAXD = SCAN_DIV > GAP_CYC ? SCAN_DIV : GAP_CYC;
  localparam int PW = $clog2(MAXD + 1);
  localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(GAP_CYC - 1);
  logic [3:0] val_reg, ones, tens, ones_q, tens_q;
  logic [PW-1:0] phase;
  logic last;
  scan_t state;
  sync_stable #(.W(4), .STABLE_CYC(STABLE_CYC)) u_sync (
    .clk_ref(clk_ref),
    .rst(rst),
    .din(cnt_in),
    .dout(val_reg)
  );
  assign tens = {3'b000, val_reg >= 4'd10};
  assign ones = val_reg >= 4'd10 ? val_reg - 4'd10 : val_reg;
  assign last = (state == S_ONES || state == S_TENS) ? phase == SCAN_LAST : phase == GAP_LAST;
  assign dp = 1'b1;
  // digits latch only when the tens digit goes dark, so a lit digit never changes mid-frame
  always_ff @(posedge clk_ref or negedge rst)
    if (!rst) begin
      state <= S_GAP1;
      phase <= '0;
      ones_q <= '0;
      tens_q <= '0;
      seg <= SEG_OFF;
      an <= 2'b11;
    end else begin
      phase <= last ? '0 : phase + 1'b1;
      if (last) state <= scan_t'(state + 2'd1);
      if (last && state == S_TENS) begin
        ones_q <= ones;
        tens_q <= tens;
      end
      an <= state == S_ONES ? 2'b10 : state == S_TENS ? 2'b01 : 2'b11;
      seg <= state == S_ONES ? seg_enc(ones_q) :
             state == S_TENS && !(BLANK_LZ && tens_q == 4'd0) ? seg_enc(tens_q) : SEG_OFF;
    end
endmodule

// File: tb/tb_seg7_scan_2d.sv
// tb_seg7_scan_2d: random and directed stimulus checked every cycle against a timeline model
module tb_seg7_scan_2d;
  localparam int SD = 8, G = 2, S = 4, P = 2 * (SD + G);
  localparam logic [6:0] ENC [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic clk_ref = 1'b0;
  logic rst = 1'b0;
  logic [3:0] cnt_in = 4'd0;
  logic [6:0] seg, seg_nb;
  logic [1:0] an, an_nb;
  logic dp, dp_nb;
  int total = 0, bad = 0;
  bit live = 1'b0;
  bit ok, seen12;
  int t = 0, mval = 0, disp = 0;
  int q[$] = '{0, 0, 0};
  logic [1:0] exp_an = 2'b11;
  logic [6:0] exp_seg = 7'h7F, exp_seg_nb = 7'h7F;

  seg7_scan_2d #(.SCAN_DIV(SD), .GAP_CYC(G), .STABLE_CYC(S), .BLANK_LZ(1'b1)) dut (
    .clk_ref(clk_ref), .rst(rst), .cnt_in(cnt_in), .seg(seg), .an(an), .dp(dp));
  seg7_scan_2d #(.SCAN_DIV(SD), .GAP_CYC(G), .STABLE_CYC(S), .BLANK_LZ(1'b0)) dut_nb (
    .clk_ref(clk_ref), .rst(rst), .cnt_in(cnt_in), .seg(seg_nb), .an(an_nb), .dp(dp_nb));

  always #5 clk_ref = ~clk_ref;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // scan position after tt clock edges since reset release: 0 ones, 1 gap, 2 tens, 3 gap
  function automatic int st(input int tt);
    int u;
    u = tt - G;
    if (u < 0) return 3;
    u = u % P;
    return u < SD ? 0 : u < SD + G ? 1 : u < 2 * SD + G ? 2 : 3;
  endfunction

  always @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      t = 0; mval = 0; disp = 0; q = '{0, 0, 0};
      exp_an = 2'b11; exp_seg = 7'h7F; exp_seg_nb = 7'h7F;
    end else begin
      exp_an = st(t) == 0 ? 2'b10 : st(t) == 2 ? 2'b01 : 2'b11;
      exp_seg = st(t) == 0 ? ENC[disp % 10] : (st(t) == 2 && disp >= 10) ? ENC[1] : 7'h7F;
      exp_seg_nb = st(t) == 0 ? ENC[disp % 10] : st(t) == 2 ? ENC[disp / 10] : 7'h7F;
      if (st(t) == 2 && st(t + 1) == 3) disp = mval;
      // accept a value once S+1 consecutive samples agree, two samples behind the pins
      if (q.size() >= S + 2) begin
        ok = 1'b1;
        for (int k = 0; k <= S; k++) if (q[q.size() - 2 - k] != q[q.size() - 2]) ok = 1'b0;
        if (ok) mval = q[q.size() - 2];
      end
      q.push_back(int'(cnt_in));
      if (q.size() > S + 2) void'(q.pop_front());
      t++;
    end
  end

  always @(negedge clk_ref) if (live) begin
    chk("an", int'(an), int'(exp_an));
    chk("seg", int'(seg), int'(exp_seg));
    chk("an_nb", int'(an_nb), int'(exp_an));
    chk("seg_nb", int'(seg_nb), int'(exp_seg_nb));
    chk("dp", int'(dp & dp_nb), 1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_ref);
  endtask

  task automatic wait_an(input logic [1:0] v, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk_ref);
      n++;
    end while (an != v && n < 100);
    if (an != v) begin
      total++;
      bad++;
      $display("FAIL %s timeout: an=%b want %b", nm, an, v);
    end
  endtask

  initial begin
    tick(3);
    live = 1'b1;
    tick(1);
    chk("rst_seg", int'(seg), 'h7F);
    chk("rst_an", int'(an), 'h3);
    chk("rst_dp", int'(dp), 1);
    rst = 1'b1;
    tick(2);
    chk("rel_gap_an", int'(an), 'h3);
    tick(1);
    chk("rel_first_an", int'(an), 'h2);
    chk("rel_first_seg", int'(seg), 'h40);

    cnt_in = 4'd7;
    tick(45);
    wait_an(2'b11, "v7_gap"); wait_an(2'b10, "v7_ones");
    chk("v7_ones", int'(seg), 'h78);
    wait_an(2'b01, "v7_tens");
    chk("v7_tens_blank", int'(seg), 'h7F);
    chk("v7_tens_noblank", int'(seg_nb), 'h40);

    cnt_in = 4'd15;
    tick(45);
    wait_an(2'b11, "v15_gap"); wait_an(2'b10, "v15_ones");
    chk("v15_ones", int'(seg), 'h12);
    wait_an(2'b01, "v15_tens");
    chk("v15_tens", int'(seg), 'h79);

    cnt_in = 4'd3;
    tick(45);
    cnt_in = 4'd12;
    tick(3);
    cnt_in = 4'd3;
    seen12 = 1'b0;
    repeat (60) begin
      @(negedge clk_ref);
      if (an == 2'b01 && seg == 7'h79) seen12 = 1'b1;
    end
    chk("glitch_hidden", int'(seen12), 0);

    cnt_in = 4'd9;
    tick(45);
    wait_an(2'b11, "latch_gap"); wait_an(2'b10, "latch_ones");
    tick(3);
    cnt_in = 4'd10;
    for (int i = 0; i < 20 && an == 2'b10; i++) begin
      chk("latch_hold9", int'(seg), 'h10);
      @(negedge clk_ref);
    end
    wait_an(2'b11, "latch_gap2"); wait_an(2'b10, "latch_ones2");
    chk("latch_ones0", int'(seg), 'h40);
    wait_an(2'b01, "latch_tens1");
    chk("latch_tens1", int'(seg), 'h79);

    tick(3);
    @(posedge clk_ref);
    #3 rst = 1'b0;
    #1;
    chk("midrst_an", int'(an), 'h3);
    chk("midrst_seg", int'(seg), 'h7F);
    tick(2);
    rst = 1'b1;
    tick(3);
    chk("midrst_ones", int'(seg), 'h40);
    chk("midrst_an_ones", int'(an), 'h2);
    tick(50);

    repeat (150) begin
      cnt_in = 4'($urandom_range(0, 15));
      tick($urandom_range(1, 25));
    end
    tick(50);
    live = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
